// File: rtl/noc_filereg_pkg.sv
// Shared types, widths and packing helpers for the NoC config register-file agent.
package noc_filereg_pkg;

   typedef enum logic {OP_READ = 1'b0, OP_WRITE = 1'b1} op_e;
   typedef enum logic {ST_OK = 1'b0, ST_ERR = 1'b1} status_e;

   localparam int unsigned ERR_CNT_WIDTH = 16;
   localparam int unsigned FIELD_MAX_W   = 64;
   localparam int unsigned PKT_MAX_W     = 256;

   typedef logic [FIELD_MAX_W-1:0] field_t;
   typedef logic [PKT_MAX_W-1:0]   pkt_t;

   // Low w bits set; callers truncate packets back to their real width.
   function automatic field_t field_mask(input int unsigned w);
      field_t m;
      if (w >= FIELD_MAX_W) m = '1;
      else                  m = (field_t'(1) << w) - field_t'(1);
      return m;
   endfunction

   function automatic pkt_t pack_req(input int unsigned aw, input int unsigned dw,
                                     input op_e op, input field_t addr, input field_t wdata);
      pkt_t p;
      p = pkt_t'(wdata & field_mask(dw));
      p = p | (pkt_t'(addr & field_mask(aw)) << dw);
      p = p | (pkt_t'(op) << (aw + dw));
      return p;
   endfunction

   function automatic op_e unpack_op(input int unsigned aw, input int unsigned dw, input pkt_t p);
      logic b;
      b = 1'(p >> (aw + dw));
      return op_e'(b);
   endfunction

   function automatic field_t unpack_addr(input int unsigned aw, input int unsigned dw, input pkt_t p);
      return field_t'(p >> dw) & field_mask(aw);
   endfunction

   function automatic field_t unpack_wdata(input int unsigned dw, input pkt_t p);
      return field_t'(p) & field_mask(dw);
   endfunction

   function automatic pkt_t pack_resp(input int unsigned tw, input int unsigned aw,
                                      input int unsigned dw, input field_t tile_id,
                                      input status_e st, input field_t addr, input field_t rdata);
      pkt_t p;
      p = pkt_t'(rdata & field_mask(dw));
      p = p | (pkt_t'(addr & field_mask(aw)) << dw);
      p = p | (pkt_t'(st) << (aw + dw));
      p = p | (pkt_t'(tile_id & field_mask(tw)) << (aw + dw + 1));
      return p;
   endfunction

endpackage

// File: rtl/noc_filereg_resp_fifo.sv
// Synchronous response FIFO with occupancy count and first-word-fallthrough head.
module noc_filereg_resp_fifo #(
   parameter int unsigned Width = 8,
   parameter int unsigned Depth = 4
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       push_i,
   input  logic [Width-1:0]           data_i,
   input  logic                       pop_i,
   output logic [Width-1:0]           data_o,
   output logic [$clog2(Depth):0]     count_o,
   output logic                       empty_o
);

   localparam int unsigned PtrW = $clog2(Depth);
   localparam int unsigned CntW = PtrW + 1;

   logic [Width-1:0] mem_q [Depth];
   logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0]  count_q;
   logic             full, do_push, do_pop;

   assign full    = (count_q == CntW'(Depth));
   assign empty_o = (count_q == '0);
   assign do_push = push_i & ~full;
   assign do_pop  = pop_i & ~empty_o;
   assign data_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
   end

   // Depth is a power of two, so pointers wrap by plain overflow.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CntW'(1);
            2'b01:   count_q <= count_q - CntW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/noc_filereg_agent.sv
// Router config register-file endpoint: RW/RO registers, error counter, tagged response queue.
// Build option FILEREG_WRITE_ACK_EN: accepted writes also push a response.
module noc_filereg_agent
   import noc_filereg_pkg::*;
#(
   parameter int unsigned          DataWidth     = 32,
   parameter int unsigned          AddrWidth     = 6,
   parameter int unsigned          NumRegs       = 16,
   parameter int unsigned          TileIdWidth   = 4,
   parameter int unsigned          TileId        = 0,
   parameter int unsigned          RespFifoDepth = 4,
   parameter logic [NumRegs-1:0]   RoMask        = '0
) (
   input  logic                                        clk_i,
   input  logic                                        rst_i,
   input  logic                                        s_req_valid_i,
   output logic                                        s_req_ready_o,
   input  logic [AddrWidth+DataWidth:0]                s_req_data_i,
   output logic                                        m_resp_valid_o,
   input  logic                                        m_resp_ready_i,
   output logic [TileIdWidth+AddrWidth+DataWidth:0]    m_resp_data_o,
   input  logic [NumRegs*DataWidth-1:0]                ro_value_i,
   output logic [NumRegs*DataWidth-1:0]                cfg_regs_o
);

   localparam int unsigned RespW = TileIdWidth + 1 + AddrWidth + DataWidth;
   localparam int unsigned IdxW  = (NumRegs > 1) ? $clog2(NumRegs) : 1;
   localparam int unsigned CntW  = $clog2(RespFifoDepth) + 1;

   pkt_t                     req_pkt;
   op_e                      req_op;
   logic [AddrWidth-1:0]     req_addr;
   logic [DataWidth-1:0]     req_wdata;
   logic [IdxW-1:0]          reg_idx;
   logic                     in_range, is_errc, is_ro;
   logic [DataWidth-1:0]     rw_word, ro_word;

   logic [NumRegs*DataWidth-1:0] regs_q;
   logic [ERR_CNT_WIDTH-1:0]     err_cnt_q;

   logic                     accept_c, wr_ok, push, err_inc, has_space, fifo_empty;
   status_e                  resp_status;
   logic [DataWidth-1:0]     resp_rdata;
   logic [RespW-1:0]         resp_pkt;
   logic [CntW-1:0]          fifo_count;

   assign req_pkt   = pkt_t'(s_req_data_i);
   assign req_op    = unpack_op(AddrWidth, DataWidth, req_pkt);
   assign req_addr  = AddrWidth'(unpack_addr(AddrWidth, DataWidth, req_pkt));
   assign req_wdata = DataWidth'(unpack_wdata(DataWidth, req_pkt));

   // Address decode; the top address is reserved for the error counter.
   assign reg_idx  = IdxW'(req_addr);
   assign in_range = (32'(req_addr) < NumRegs);
   assign is_errc  = &req_addr;
   assign is_ro    = RoMask[reg_idx];
   assign rw_word  = regs_q[reg_idx*DataWidth +: DataWidth];
   assign ro_word  = ro_value_i[reg_idx*DataWidth +: DataWidth];

   assign has_space = (fifo_count < CntW'(RespFifoDepth));
`ifdef FILEREG_WRITE_ACK_EN
   assign s_req_ready_o = ~rst_i & has_space;
`else
   assign s_req_ready_o = ~rst_i & ((req_op == OP_WRITE) | has_space);
`endif
   assign accept_c = s_req_valid_i & s_req_ready_o;

   always_comb begin
      wr_ok       = 1'b0;
      resp_status = ST_OK;
      resp_rdata  = '0;
      push        = 1'b0;
      if (req_op == OP_WRITE) begin
         wr_ok       = in_range & ~is_ro;
         resp_status = wr_ok ? ST_OK : ST_ERR;
         resp_rdata  = wr_ok ? req_wdata : '0;
`ifdef FILEREG_WRITE_ACK_EN
         push        = accept_c;
`endif
      end else begin
         push = accept_c;
         if (in_range)     resp_rdata  = is_ro ? ro_word : rw_word;
         else if (is_errc) resp_rdata  = DataWidth'(err_cnt_q);
         else              resp_status = ST_ERR;
      end
   end

   assign err_inc  = accept_c & (resp_status == ST_ERR);
   assign resp_pkt = RespW'(pack_resp(TileIdWidth, AddrWidth, DataWidth, field_t'(TileId),
                                      resp_status, field_t'(req_addr), field_t'(resp_rdata)));

   // Register array and saturating error counter.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         regs_q    <= '0;
         err_cnt_q <= '0;
      end else begin
         if (accept_c && wr_ok) regs_q[reg_idx*DataWidth +: DataWidth] <= req_wdata;
         if (err_inc && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + ERR_CNT_WIDTH'(1);
      end
   end

   noc_filereg_resp_fifo #(
      .Width (RespW),
      .Depth (RespFifoDepth)
   ) u_resp_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (push),
      .data_i  (resp_pkt),
      .pop_i   (m_resp_ready_i),
      .data_o  (m_resp_data_o),
      .count_o (fifo_count),
      .empty_o (fifo_empty)
   );

   assign m_resp_valid_o = ~fifo_empty;
   assign cfg_regs_o     = regs_q;

endmodule

// File: tb/tb_noc_filereg_agent.sv
// Randomised bench for noc_filereg_agent against a queue/array reference model.
module tb_noc_filereg_agent;

   localparam int unsigned DW    = 32;
   localparam int unsigned AW    = 6;
   localparam int unsigned NR    = 16;
   localparam int unsigned DEPTH = 4;
   localparam logic [15:0] RO_MASK = 16'h0011;

   logic             clk_i = 1'b0;
   logic             rst_i = 1'b1;
   logic             s_req_valid_i = 1'b0;
   logic             s_req_ready_o;
   logic [38:0]      s_req_data_i = '0;
   logic             m_resp_valid_o;
   logic             m_resp_ready_i = 1'b0;
   logic [42:0]      m_resp_data_o;
   logic [511:0]     ro_value_i = '0;
   logic [511:0]     cfg_regs_o;

   int n_cmp = 0;
   int n_bad = 0;

   logic [31:0] m_regs [16];
   logic [31:0] ro_word [16];
   int          m_err;
   logic [42:0] exp_q [$];
   logic [15:0] ro_mask_v;
   bit          rand_ro;

   noc_filereg_agent #(
      .DataWidth     (DW),
      .AddrWidth     (AW),
      .NumRegs       (NR),
      .TileIdWidth   (4),
      .TileId        (0),
      .RespFifoDepth (DEPTH),
      .RoMask        (RO_MASK)
   ) dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .s_req_valid_i  (s_req_valid_i),
      .s_req_ready_o  (s_req_ready_o),
      .s_req_data_i   (s_req_data_i),
      .m_resp_valid_o (m_resp_valid_o),
      .m_resp_ready_i (m_resp_ready_i),
      .m_resp_data_o  (m_resp_data_o),
      .ro_value_i     (ro_value_i),
      .cfg_regs_o     (cfg_regs_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One clock of stimulus: drive, check against the model, then advance the model past the edge.
   task automatic do_cycle(input logic rst, input logic vld, input logic wr,
                           input logic [5:0] addr, input logic [31:0] wd, input logic rr);
      logic        exp_rdy, acc, pop, st, push;
      logic [31:0] rd;
      int          a;
      @(negedge clk_i);
      if (rand_ro) begin
         for (int i = 0; i < 16; i++) ro_word[i] = $urandom;
      end
      for (int i = 0; i < 16; i++) ro_value_i[i*32 +: 32] = ro_word[i];
      rst_i          = rst;
      s_req_valid_i  = vld;
      s_req_data_i   = {wr, addr, wd};
      m_resp_ready_i = rr;
      #2;
`ifdef FILEREG_WRITE_ACK_EN
      exp_rdy = !rst && (exp_q.size() < DEPTH);
`else
      exp_rdy = !rst && (wr || (exp_q.size() < DEPTH));
`endif
      check_eq("req_ready", 64'(s_req_ready_o), 64'(exp_rdy));
      check_eq("resp_valid", 64'(m_resp_valid_o), 64'(exp_q.size() != 0));
      if (exp_q.size() != 0) check_eq("resp_data", 64'(m_resp_data_o), 64'(exp_q[0]));
      for (int i = 0; i < 16; i++) check_eq("cfg_reg", 64'(cfg_regs_o[i*32 +: 32]), 64'(m_regs[i]));

      acc = vld && exp_rdy;
      pop = (exp_q.size() != 0) && rr;
      if (rst) begin
         exp_q.delete();
         for (int i = 0; i < 16; i++) m_regs[i] = '0;
         m_err = 0;
      end else begin
         if (pop) void'(exp_q.pop_front());
         if (acc) begin
            a = int'(addr);
            st = 1'b0;
            rd = '0;
            if (wr) begin
               if (a < 16 && !ro_mask_v[a]) begin
                  m_regs[a] = wd;
                  rd = wd;
               end else begin
                  st = 1'b1;
               end
`ifdef FILEREG_WRITE_ACK_EN
               push = 1'b1;
`else
               push = 1'b0;
`endif
            end else begin
               push = 1'b1;
               if (a < 16)       rd = ro_mask_v[a] ? ro_word[a] : m_regs[a];
               else if (a == 63) rd = 32'(m_err);
               else              st = 1'b1;
            end
            if (st && m_err < 65535) m_err++;
            if (push) exp_q.push_back({4'h0, st, addr, rd});
         end
      end
      @(posedge clk_i);
   endtask

   logic [42:0] exp_v;

   initial begin
      ro_mask_v = RO_MASK;
      rand_ro   = 1'b0;
      m_err     = 0;
      for (int i = 0; i < 16; i++) begin
         m_regs[i]  = '0;
         ro_word[i] = 32'h0;
      end
      ro_word[0] = 32'h1234;
      ro_word[4] = 32'hCAFE_0004;

      repeat (3) do_cycle(1, 0, 0, 6'd0, 32'h0, 1);

      // Write then read back a RW register.
      do_cycle(0, 1, 1, 6'd3, 32'hDEADBEEF, 1);
      do_cycle(0, 1, 0, 6'd3, 32'h0, 1);
      #1;
      exp_v = {4'h0, 1'b0, 6'd3, 32'hDEADBEEF};
      check_eq("rd_reg3", 64'(m_resp_data_o), 64'(exp_v));
      check_eq("cfg_reg3", 64'(cfg_regs_o[3*32 +: 32]), 64'h0DEADBEEF);

      // Read-only protection and error counter.
      do_cycle(0, 1, 1, 6'd0, 32'h55, 1);
      do_cycle(0, 1, 0, 6'd0, 32'h0, 1);
      #1;
      exp_v = {4'h0, 1'b0, 6'd0, 32'h1234};
      check_eq("rd_ro0", 64'(m_resp_data_o), 64'(exp_v));
      do_cycle(0, 1, 0, 6'd63, 32'h0, 1);
      #1;
      exp_v = {4'h0, 1'b0, 6'd63, 32'd1};
      check_eq("rd_errcnt1", 64'(m_resp_data_o), 64'(exp_v));
      do_cycle(0, 1, 0, 6'd20, 32'h0, 1);
      #1;
      exp_v = {4'h0, 1'b1, 6'd20, 32'd0};
      check_eq("rd_oor", 64'(m_resp_data_o), 64'(exp_v));
      do_cycle(0, 1, 0, 6'd63, 32'h0, 1);
      #1;
      exp_v = {4'h0, 1'b0, 6'd63, 32'd2};
      check_eq("rd_errcnt2", 64'(m_resp_data_o), 64'(exp_v));

      // Back-pressure: four reads fill the queue, the fifth stalls.
      do_cycle(0, 0, 0, 6'd0, 32'h0, 1);
      do_cycle(0, 1, 0, 6'd3, 32'h0, 0);
      do_cycle(0, 1, 0, 6'd0, 32'h0, 0);
      do_cycle(0, 1, 0, 6'd63, 32'h0, 0);
      do_cycle(0, 1, 0, 6'd1, 32'h0, 0);
      do_cycle(0, 1, 0, 6'd2, 32'h0, 0);
      repeat (4) do_cycle(0, 0, 0, 6'd0, 32'h0, 1);
      do_cycle(0, 1, 0, 6'd2, 32'h0, 1);

      do_cycle(0, 1, 1, 6'd5, 32'd7, 1);
`ifdef FILEREG_WRITE_ACK_EN
      #1;
      exp_v = {4'h0, 1'b0, 6'd5, 32'd7};
      check_eq("wr_ack5", 64'(m_resp_data_o), 64'(exp_v));
`endif

      // Full queue, then ten back-to-back writes.
      do_cycle(0, 0, 0, 6'd0, 32'h0, 1);
      repeat (4) do_cycle(0, 1, 0, 6'd5, 32'h0, 0);
      for (int i = 0; i < 10; i++) do_cycle(0, 1, 1, 6'(i + 6), 32'(i * 17 + 1), 0);
      repeat (6) do_cycle(0, 0, 0, 6'd0, 32'h0, 1);

      // Reset with three responses queued.
      repeat (3) do_cycle(0, 1, 0, 6'd5, 32'h0, 0);
      do_cycle(1, 0, 0, 6'd0, 32'h0, 0);
      #1;
      check_eq("rst_flush_valid", 64'(m_resp_valid_o), 64'h0);
      for (int i = 0; i < 16; i++) do_cycle(0, 1, 0, 6'(i), 32'h0, 1);
      do_cycle(0, 0, 0, 6'd0, 32'h0, 1);

      // Randomised traffic.
      rand_ro = 1'b1;
      for (int n = 0; n < 3000; n++) begin
         int          sel;
         logic [5:0]  ad;
         sel = int'($urandom_range(0, 9));
         if (sel < 6)      ad = 6'($urandom_range(0, 15));
         else if (sel < 8) ad = 6'd63;
         else              ad = 6'($urandom);
         do_cycle(($urandom_range(0, 299) == 0), ($urandom_range(0, 9) < 7),
                  1'($urandom), ad, $urandom, ($urandom_range(0, 9) < 6));
      end
      repeat (8) do_cycle(0, 0, 0, 6'd0, 32'h0, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
